spi_frame_rx: RTL
=================

Name: spi_frame_rx

Overview:
- Parametrised successor to the byte-framed serial receiver feeding the crypto datapath.
- Decodes the 3-slot bit frame on SPIin, qualified by spi_en: start slot = 1, data slot = D, stop slot = 0.
- Assembles WIDTH data bits into a word and pushes it into a DEPTH-entry output FIFO with a valid/ready handshake.
- Adds behaviour the first generation lacked: framing-error detection, inter-bit timeout, selectable bit order, overrun reporting.

Parameters:
- WIDTH, 8: data bits per word (2..64).
- DEPTH, 4: output FIFO entries (power of 2, >=2).
- MSB_FIRST, 1: 1 = first received bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0].
- TIMEOUT, 255: idle clocks without spi_en, while a word is partial, before the partial word is aborted (>=1).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- SPIin  in  1  serial frame slot value.
- spi_en  in  1  slot qualifier; a slot is consumed only in cycles where spi_en=1.
- data_out  out  WIDTH  FIFO head word.
- data_valid  out  1  FIFO non-empty.
- data_ready  in  1  consumer accepts head when data_valid && data_ready.
- frame_err  out  1  one-cycle pulse on a bad start/stop slot or a timeout.
- overrun  out  1  one-cycle pulse when a completed word is dropped because the FIFO is full.
- fill  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, async): state=S_START; bit count, shift register and timeout counter cleared; FIFO emptied. Outputs: data_out=0, data_valid=0, frame_err=0, overrun=0, fill=0.
- Reset mid-word discards the partial word.
- FSM states (advance only on spi_en=1; spi_en=0 holds state):
  - S_START: SPIin=1 -> S_DATA. SPIin=0 -> frame_err pulse, bit count cleared, stay in S_START.
  - S_DATA: sample SPIin into the shift register at position per MSB_FIRST -> S_STOP.
  - S_STOP: SPIin=0 -> bit accepted, bit count +1, go to S_START. SPIin=1 -> frame_err pulse, whole partial word discarded, bit count=0, S_START.
- Word completion: the accepted stop slot that brings bit count to WIDTH. The word is written to the FIFO on that edge; data_valid rises the next cycle if the FIFO was empty (1-cycle latency). Bit count returns to 0.
- FIFO full at completion: word dropped, overrun pulses, FIFO unchanged.
- Push and pop in the same cycle, FIFO full: the pop frees the slot, so the push succeeds with no overrun. Fill stays DEPTH.
- Push and pop in the same cycle, FIFO empty: no bypass; the pushed word appears next cycle.
- Read pointer and write pointer wrap modulo DEPTH; fill is the true occupancy, 0..DEPTH.
- data_out is the registered FIFO head. It is stable while data_valid=1 && data_ready=0, and undefined-but-held (last value) when empty.
- Timeout counter:
  - Runs only while bit count>0, or while state!=S_START.
  - Clears on any spi_en=1 cycle.
  - Reaching TIMEOUT: frame_err pulse, partial word discarded, state=S_START, counter=0.
- frame_err and overrun are registered single-cycle pulses. Both may assert in the same cycle.

Decomposition:
- Shared package spi_frame_pkg: state encoding (S_START=2'b00, S_DATA=2'b01, S_STOP=2'b10) and the frame slot constants START_BIT=1, STOP_BIT=0.
- One sub-module, sync_fifo (WIDTH, DEPTH): push/pop/full/empty/fill. It is reused elsewhere in the crypto datapath.
- The FSM, shifter and timeout counter stay in the top level.

Test Plan:
1. WIDTH=8, MSB_FIRST=1: send 0xA5 as 8 frames (1,D,0) with spi_en=1 every cycle, data_ready=1 -> data_out=0xA5, data_valid=1 exactly 1 cycle after the 24th slot, for one cycle; no frame_err.
2. MSB_FIRST=0: send bit sequence 1,0,1,0,0,1,0,1 -> data_out=0xA5 (LSB-first assembly).
3. Stop slot driven 1 on the 4th bit of 0x3C -> frame_err pulses once, no word pushed; then a clean 0x3C -> data_out=0x3C.
4. DEPTH=4, data_ready=0: send 5 words 0x01..0x05 -> fill=4 after word 4, overrun pulses at word 5's final stop slot. Then release data_ready -> pops 0x01,0x02,0x03,0x04 in order, fill=0.
5. TIMEOUT=16: send 3 bits, then hold spi_en=0 for 16 cycles -> frame_err on the 16th idle cycle. The next full word 0xC3 is received intact.
6. Assert reset low mid-word (after 5 bits) with FIFO holding 2 words -> data_valid=0 and fill=0 immediately (async). After release, a clean 0x7E decodes correctly.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// Shared encodings for the serial frame receiver: FSM states and frame slot values.
package spi_frame_pkg;

  typedef enum logic [1:0] {
    S_START = 2'b00,
    S_DATA  = 2'b01,
    S_STOP  = 2'b10
  } state_e;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; a pop frees a full slot for a same-cycle push.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] fill_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign fill_o  = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: storage is reset so the head reads 0 out of reset; fine at this depth,
  // but large FIFOs should leave the array unreset and map onto RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_frame_rx.sv
// Start/data/stop slot decoder that assembles WIDTH-bit words into an output FIFO,
// flagging framing errors, inter-bit timeouts and FIFO overruns.
module spi_frame_rx
  import spi_frame_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   SPIin,
  input  logic                   spi_en,
  output logic [WIDTH-1:0]       data_out,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic                   frame_err,
  output logic                   overrun,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             word_done, fifo_full, fifo_empty;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tmo_d       = tmo_q;
    frame_err_d = 1'b0;
    word_done   = 1'b0;
    if (spi_en) begin
      tmo_d = '0;
      unique case (state_q)
        S_START: begin
          if (SPIin == START_BIT) begin
            state_d = S_DATA;
          end else begin
            frame_err_d = 1'b1;
            bit_cnt_d   = '0;
          end
        end
        S_DATA: begin
          shift_d = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], SPIin}
                                     : {SPIin, shift_q[WIDTH-1:1]};
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_START;
          if (SPIin != STOP_BIT) begin
            frame_err_d = 1'b1;
            bit_cnt_d   = '0;
          end else if (bit_cnt_q == CW'(WIDTH - 1)) begin
            word_done = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
        default: state_d = S_START;
      endcase
    end else if (bit_cnt_q != '0 || state_q != S_START) begin
      // Idle inside a partial word: abort once TIMEOUT idle clocks accumulate.
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        frame_err_d = 1'b1;
        state_d     = S_START;
        bit_cnt_d   = '0;
        tmo_d       = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // A push into a full FIFO survives only when the head is popped on the same edge.
  assign overrun_d = word_done && fifo_full && !(data_valid && data_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_START;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .push_i  (word_done),
    .wdata_i (shift_q),
    .pop_i   (data_ready),
    .rdata_o (data_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .fill_o  (fill)
  );

  assign data_valid = !fifo_empty;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
